// File: rtl/chan_rr_scheduler_pkg.sv
// Shared constants for the channel round-robin scheduler: FSM encodings and
// beat-counter sizing.
package chan_rr_scheduler_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int BEAT_CNT_W = 16;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

endpackage

// File: rtl/n_channel_mux.sv
// Combinational N-way word selector; an out-of-range select yields zero.
module n_channel_mux #(
  parameter int N_INPUTS    = 8,
  parameter int INPUT_WIDTH = 22,
  parameter int SEL_WIDTH   = 5
) (
  input  logic [N_INPUTS*INPUT_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]            sel,
  output logic [INPUT_WIDTH-1:0]          out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) out_data = in_data[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

endmodule

// File: rtl/chan_rr_scheduler.sv
// Round-robin packet scheduler: grants one channel at a time and holds the
// grant until that channel's last beat is accepted downstream.
module chan_rr_scheduler
  import chan_rr_scheduler_pkg::*;
#(
  parameter int N_INPUTS    = 8,
  parameter int INPUT_WIDTH = 22,
  parameter int SEL_WIDTH   = 5,
  parameter int MAX_BURST   = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [N_INPUTS*INPUT_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]             in_valid,
  input  logic [N_INPUTS-1:0]             in_last,
  output logic [N_INPUTS-1:0]             in_ready,
  output logic [INPUT_WIDTH-1:0]          out_data,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [SEL_WIDTH-1:0]            sel,
  output logic                            busy,
  output logic                            overlength
);

  logic [0:0]            state;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [SEL_WIDTH-1:0]  next_sel;
  logic [SEL_WIDTH-1:0]  next_ptr;
  logic                  found;
  logic                  xfer;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  beat;
  logic                  burst_hit;
  int                    off;
  int                    best_off;

  // Each candidate's distance from ptr (with wrap); the nearest valid one wins.
  always_comb begin
    found    = 1'b0;
    next_sel = '0;
    best_off = N_INPUTS;
    off      = 0;
    for (int k = 0; k < N_INPUTS; k++) begin
      off = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + N_INPUTS - int'(ptr));
      if (in_valid[k] && (off < best_off)) begin
        best_off = off;
        next_sel = SEL_WIDTH'(k);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    in_ready  = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_valid   = in_valid[k];
        sel_last    = in_last[k];
        in_ready[k] = xfer & out_ready;
      end
    end
  end

  n_channel_mux #(
    .N_INPUTS    (N_INPUTS),
    .INPUT_WIDTH (INPUT_WIDTH),
    .SEL_WIDTH   (SEL_WIDTH)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (out_data)
  );

  assign xfer      = (state == ST_XFER);
  assign busy      = xfer;
  assign out_valid = xfer & sel_valid;
  assign out_last  = xfer & sel_last;
  assign beat      = out_valid & out_ready;
  assign next_ptr  = (sel == SEL_WIDTH'(N_INPUTS - 1)) ? '0 : sel + SEL_WIDTH'(1);
  // The beat being accepted now is number beat_cnt+1 of this grant.
  assign burst_hit = (int'(beat_cnt) + 1) >= MAX_BURST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      ptr        <= '0;
      beat_cnt   <= '0;
      overlength <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && found) begin
            sel      <= next_sel;
            beat_cnt <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            if (beat_cnt != BEAT_CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (!out_last && burst_hit) overlength <= 1'b1;
            if (out_last) begin
              state <= ST_IDLE;
              ptr   <= next_ptr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_rr_scheduler.sv
// Self-checking bench for chan_rr_scheduler: directed scenarios plus a random
// phase, all judged against a transaction-level reference model.
module tb_chan_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = 3;
  localparam int MB = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           en    = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [SW-1:0]  sel;
  logic           busy;
  logic           overlength;

  chan_rr_scheduler #(
    .N_INPUTS    (N),
    .INPUT_WIDTH (W),
    .SEL_WIDTH   (SW),
    .MAX_BURST   (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy),
    .overlength (overlength)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-channel packet sources
  int           rem[N];
  int           pkts_left[N];
  int           pkt_len[N];
  int           seq[N];
  bit           holding[N];
  bit           vld[N];
  bit           lst[N];
  logic [W-1:0] chan_data[N];
  int           valid_pct;
  int           ready_pct;
  int           en_pct;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign in_valid[g]         = vld[g];
    assign in_last[g]          = lst[g];
    assign in_data[g*W +: W]   = chan_data[g];
  end

  // Reference model: owner -1 means nobody holds the grant
  int m_owner, m_ptr, m_sel, m_beats;
  bit m_over;
  int n_owner, n_ptr, n_sel, n_beats;
  bit n_over;
  int acc;
  logic [N-1:0] exp_ir;
  logic [W-1:0] exp_data;
  bit exp_busy, exp_ov, exp_ol;

  int grant_log[$];
  int grant_cyc[$];
  int obs_beats;
  int ov_at;
  int cyc;
  bit prev_busy, prev_over;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setSrc(input int k, input int npk, input int len);
    pkts_left[k] = npk;
    pkt_len[k]   = len;
  endtask

  task automatic clearSources;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0; pkts_left[k] = 0; pkt_len[k] = 0; holding[k] = 1'b0;
    end
  endtask

  task automatic applyStimulus;
    for (int k = 0; k < N; k++) begin
      if (rem[k] == 0 && pkts_left[k] != 0) begin
        rem[k] = (pkt_len[k] > 0) ? pkt_len[k] : int'($urandom_range(1, 6));
        if (pkts_left[k] > 0) pkts_left[k]--;
      end
      if (rem[k] == 0) holding[k] = 1'b0;
      else if (!holding[k]) holding[k] = (int'($urandom_range(0, 99)) < valid_pct);
      vld[k]       = holding[k];
      lst[k]       = (rem[k] == 1);
      chan_data[k] = W'((k << 12) | (seq[k] & 'hfff));
    end
    en        = (int'($urandom_range(0, 99)) < en_pct);
    out_ready = (int'($urandom_range(0, 99)) < ready_pct);
  endtask

  task automatic modelReset;
    m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0; m_over = 1'b0;
    grant_log.delete(); grant_cyc.delete();
    obs_beats = 0; ov_at = -1; prev_busy = 1'b0; prev_over = 1'b0;
  endtask

  // Expected outputs for the current cycle and the state after the next edge
  task automatic modelEval;
    logic [N-1:0] one;
    one = 1;
    n_owner = m_owner; n_ptr = m_ptr; n_sel = m_sel; n_beats = m_beats; n_over = m_over;
    acc = -1; exp_ir = '0; exp_data = '0; exp_ov = 1'b0; exp_ol = 1'b0;
    exp_busy = (m_owner >= 0);
    if (m_owner < 0) begin
      if (en) begin
        for (int i = 0; i < N; i++) begin
          if (n_owner < 0 && vld[(m_ptr + i) % N]) begin
            n_owner = (m_ptr + i) % N;
            n_sel   = n_owner;
            n_beats = 0;
          end
        end
      end
    end else begin
      exp_ov   = vld[m_owner];
      exp_ol   = lst[m_owner];
      exp_data = chan_data[m_owner];
      if (out_ready) exp_ir = one << m_owner;
      if (exp_ov && out_ready) begin
        acc     = m_owner;
        n_beats = (m_beats < 65535) ? m_beats + 1 : m_beats;
        if (n_beats >= MB && !lst[m_owner]) n_over = 1'b1;
        if (lst[m_owner]) begin
          n_ptr   = (m_owner + 1) % N;
          n_owner = -1;
        end
      end
    end
  endtask

  task automatic checkCycle;
    @(negedge clk);
    modelEval;
    checkOutput("busy", busy, exp_busy);
    checkOutput("sel", sel, m_sel);
    checkOutput("out_valid", out_valid, exp_ov);
    checkOutput("out_last", out_last, exp_ol);
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("overlength", overlength, m_over);
    if (exp_busy) checkOutput("out_data", out_data, exp_data);
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(sel));
      grant_cyc.push_back(cyc);
    end
    if (overlength && !prev_over) ov_at = obs_beats;
    if (out_valid && out_ready) obs_beats++;
    prev_busy = busy;
    prev_over = overlength;
    cyc++;
  endtask

  task automatic stepCycle;
    checkCycle;
    @(posedge clk);
    #1;
    m_owner = n_owner; m_ptr = n_ptr; m_sel = n_sel; m_beats = n_beats; m_over = n_over;
    if (acc >= 0) begin
      seq[acc]++;
      rem[acc]--;
      holding[acc] = 1'b0;
    end
    applyStimulus;
  endtask

  // Asynchronous assertion is checked before any clock edge can act
  task automatic resetDut;
    rst_n = 1'b0;
    modelReset;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_overlength", overlength, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus;
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    cyc = 0;
    for (int k = 0; k < N; k++) seq[k] = 0;
    clearSources;
    valid_pct = 100; ready_pct = 100; en_pct = 100;
    applyStimulus;
    #1;

    // Two channels, two-beat packets: ch1 then ch3 with one idle cycle between
    $display("[TB] two-channel ordering");
    clearSources;
    setSrc(1, 1, 2);
    setSrc(3, 1, 2);
    resetDut;
    repeat (10) stepCycle;
    checkOutput("order_count", grant_log.size(), 2);
    checkOutput("order_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    checkOutput("order_second", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    checkOutput("order_gap", (grant_cyc.size() > 1) ? grant_cyc[1] - grant_cyc[0] : -1, 3);

    $display("[TB] continuous single-beat requests");
    clearSources;
    for (int k = 0; k < N; k++) setSrc(k, -1, 1);
    resetDut;
    for (int c = 0; c < 40 && grant_log.size() < 5; c++) stepCycle;
    checkOutput("rr_count", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      checkOutput("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_rr[i]);

    $display("[TB] downstream stall");
    clearSources;
    setSrc(2, 1, 3);
    ready_pct = 0;
    resetDut;
    stepCycle;
    repeat (5) stepCycle;
    checkOutput("stall_beats", obs_beats, 0);
    ready_pct = 100;
    repeat (8) stepCycle;
    checkOutput("stall_done_beats", obs_beats, 3);

    $display("[TB] enable gating");
    clearSources;
    setSrc(0, 1, 4);
    setSrc(1, 1, 2);
    en_pct = 0;
    resetDut;
    repeat (5) stepCycle;
    checkOutput("en_low_grants", grant_log.size(), 0);
    en_pct = 100;
    en = 1'b1;
    stepCycle;
    en_pct = 0;
    en = 1'b0;
    repeat (10) stepCycle;
    checkOutput("en_drop_grants", grant_log.size(), 1);
    checkOutput("en_drop_beats", obs_beats, 4);
    en_pct = 100;

    $display("[TB] overlength");
    clearSources;
    setSrc(1, 1, 6);
    resetDut;
    repeat (10) stepCycle;
    checkOutput("ovl_flag", overlength, 1);
    checkOutput("ovl_beats", obs_beats, 6);
    checkOutput("ovl_rise_beat", ov_at, 4);
    repeat (3) stepCycle;
    checkOutput("ovl_sticky", overlength, 1);

    $display("[TB] reset mid-packet");
    clearSources;
    setSrc(3, 1, 4);
    resetDut;
    for (int c = 0; c < 10 && obs_beats < 1; c++) stepCycle;
    checkOutput("mid_first_beat", obs_beats, 1);
    checkCycle;
    #2;
    setSrc(0, 1, 1);
    resetDut;
    repeat (4) stepCycle;
    checkOutput("rst_restart", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("[TB] random traffic");
    clearSources;
    for (int k = 0; k < N; k++) setSrc(k, -1, 0);
    valid_pct = 60; ready_pct = 70; en_pct = 85;
    resetDut;
    repeat (1500) stepCycle;
    checkOutput("random_activity", obs_beats > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chan_rr_scheduler.md
CHAN_RR_SCHEDULER -- requirements
Module: chan_rr_scheduler

Interface
REQ-001 Parameter N_INPUTS, default 8: number of requesting channels.
REQ-002 Parameter INPUT_WIDTH, default 22: data word width per channel.
REQ-003 Parameter SEL_WIDTH, default 5: width of channel select; N_INPUTS SHALL be <= 2**SEL_WIDTH.
REQ-004 Parameter MAX_BURST, default 1024: beat limit per grant before the overlength flag sets.
REQ-005 clk  input  1  the block's one clock; all state SHALL change on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous and active-low.
REQ-007 en  input  1  when low, no new grant is issued; a packet in progress still completes.
REQ-008 in_data  input  N_INPUTS*INPUT_WIDTH  flat channel data; channel k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 in_valid  input  N_INPUTS  per-channel word-valid.
REQ-010 in_last  input  N_INPUTS  per-channel end-of-packet, qualified by in_valid.
REQ-011 in_ready  output  N_INPUTS  per-channel accept; at most one bit high.
REQ-012 out_data  output  INPUT_WIDTH  selected channel data.
REQ-013 out_valid, out_last  output  1 each  selected channel's valid and last while granted.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 sel  output  SEL_WIDTH  registered index of the granted channel.
REQ-016 busy  output  1  high while in XFER.
REQ-017 overlength  output  1  sticky flag: a grant exceeded MAX_BURST beats.

Function
REQ-018 The FSM SHALL have two states, IDLE and XFER.
REQ-019 In IDLE with en high and any in_valid bit high, the FSM SHALL register sel = first channel with in_valid high, searching upward from ptr with wrap past N_INPUTS-1 to 0, and enter XFER on the next edge.
REQ-020 In IDLE, in_ready, out_valid and out_last SHALL be 0.
REQ-021 In XFER: out_data = in_data[sel]; out_valid = in_valid[sel]; out_last = in_last[sel]; in_ready = one-hot(sel) AND out_ready; all combinational from sel.
REQ-022 A beat SHALL be counted when out_valid and out_ready are both high.
REQ-023 A beat with out_last high SHALL return the FSM to IDLE and set ptr = (sel+1) mod N_INPUTS.
REQ-024 The grant SHALL be held indefinitely while the granted channel's in_valid is low; there is no timeout.
REQ-025 Grant latency from in_valid rising in IDLE to out_valid high SHALL be one cycle; the minimum gap between packets is one IDLE cycle.
REQ-026 The beat counter SHALL be 16 bits, SHALL clear on grant, and SHALL saturate at 0xFFFF.
REQ-027 When the beat count reaches MAX_BURST without a last, overlength SHALL set and stay set until reset; the transfer SHALL continue unaffected.
REQ-028 en falling during XFER SHALL NOT abort the packet.
REQ-029 Requests from channels with index >= N_INPUTS SHALL be impossible; sel values >= N_INPUTS SHALL never be produced.
REQ-030 If a single channel requests continuously, it SHALL be re-granted after each IDLE cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, sel 0, ptr 0, beat counter 0, overlength 0, busy 0, in_ready 0, out_valid 0, out_last 0.
REQ-032 Reset asserted mid-packet SHALL drop the packet with no further beats accepted; after release, arbitration SHALL restart from channel 0.

Structure
REQ-033 A shared package/header SHALL hold the FSM state encodings and the beat-counter width constant.
REQ-034 The data path SHALL be one sub-module instance of the team's combinational n_channel_mux, driven by sel; the round-robin search SHALL stay in this module.

Verification
REQ-035 N=4; channels 1 and 3 each present a 2-beat packet; out_ready=1 -> order ch1, then ch3; sel=1 then 3; one IDLE cycle between packets.
REQ-036 All 4 channels request continuously with 1-beat packets -> grants 0,1,2,3,0 in that order.
REQ-037 Channel 2 granted; out_ready held low 5 cycles -> in_ready=0 and no beat counted; data is held stable.
REQ-038 en=0 with requests pending -> no grant; en dropped mid-packet -> packet completes, then no new grant.
REQ-039 MAX_BURST=4; 6-beat packet -> overlength rises on beat 4; all 6 beats delivered; flag persists until rst_n.
REQ-040 rst_n pulsed low during beat 2 of a channel-3 packet -> outputs immediately 0; after release, channel 0 is checked first.
